// File: rtl/choose_pkg.sv
// rtl/choose_pkg.sv - shared types, sizes and grant encoding for the choose arbiter
package choose_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [NREQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after last
module rr_pick
  import choose_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  input  logic [NREQ-1:0]  mask,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [NREQ-1:0] eff;

  assign eff = req & mask;

  // Scan from the far end so the nearest candidate after last is written last and wins.
  always_comb begin
    logic [SEL_W-1:0] idx;
    any = 1'b0;
    win = last;
    for (int i = NREQ; i >= 1; i--) begin
      idx = last + SEL_W'(i);
      if (eff[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/choose_arbiter.sv
// rtl/choose_arbiter.sv - round-robin arbiter driving choose.addr; ARB_TIMEOUT_EN adds hold limit
module choose_arbiter
  import choose_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] addr,
  output logic             busy
);

  arb_state_t       state;
  logic [SEL_W-1:0] last;
  logic [NREQ-1:0]  mask;
  logic             any;
  logic [SEL_W-1:0] win;
  logic             hold;

  if (2**CNT_W <= MAX_HOLD) begin : g_bad_cnt_w
    $error("choose_arbiter: CNT_W too narrow for MAX_HOLD");
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             expired;

  // The owner is pushed out only if someone else is actually waiting.
  assign expired = (cnt == CNT_W'(MAX_HOLD - 1)) && (|(req & ~gnt));
  assign mask    = expired ? ~gnt : '1;
  assign hold    = req[addr] && !expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == GRANT && hold) begin
      if (cnt != CNT_W'(MAX_HOLD - 1)) cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end
`else
  assign mask = '1;
  assign hold = req[addr];
`endif

  rr_pick u_pick (
    .req  (req),
    .last (last),
    .mask (mask),
    .any  (any),
    .win  (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      addr  <= '0;
      busy  <= 1'b0;
      last  <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state <= GRANT;
            gnt   <= onehot(win);
            addr  <= win;
            last  <= win;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          // While granted, last equals the owner, so the search starts just after it.
          if (!hold) begin
            if (any) begin
              gnt  <= onehot(win);
              addr <= win;
              last <= win;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
